// File: rtl/byte_word_packer_pkg.sv
// Shared constants and state encoding for the byte-lane word packer.
// The transmit-side converter and its bench use the same definitions.
package byte_word_packer_pkg;

    localparam int BYTE_W = 8;
    localparam int BYTES  = 4;
    localparam int WORD_W = BYTE_W * BYTES;
    localparam int CNT_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } pack_state_e;

endpackage

// File: rtl/byte_word_packer_sat_counter.sv
// Synchronous-reset event counter that either wraps or sticks at all-ones.
module sat_counter #(
    parameter int W        = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            if (SATURATE && (cnt_q == {W{1'b1}})) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/byte_word_packer.sv
// Packs valid-qualified bytes (MSB byte first) into words; an idle byte slot
// mid-word discards the partial word and raises a drop strobe.
module byte_word_packer
    import byte_word_packer_pkg::*;
#(
    parameter int BYTE_W = byte_word_packer_pkg::BYTE_W,
    parameter int BYTES  = byte_word_packer_pkg::BYTES,
    parameter int CNT_W  = byte_word_packer_pkg::CNT_W
) (
    input  logic                    clk_4f_i,
    input  logic                    reset_i,
    input  logic [BYTE_W-1:0]       in_data_i,
    input  logic                    in_i,
    output logic [BYTE_W*BYTES-1:0] out_data_o,
    output logic                    out_o,
    output logic                    drop_o,
    output logic [CNT_W-1:0]        word_cnt_o,
    output logic [CNT_W-1:0]        drop_cnt_o
);

    localparam int W_W    = BYTE_W * BYTES;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);

    pack_state_e       state_q, state_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [W_W-1:0]    asm_q, asm_d;
    logic [W_W-1:0]    out_data_q, out_data_d;
    logic              out_q, out_d;
    logic              drop_q, drop_d;
    logic              word_inc;
    logic              drop_inc;

    always_ff @(posedge clk_4f_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            asm_q      <= '0;
            out_data_q <= '0;
            out_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            asm_q      <= asm_d;
            out_data_q <= out_data_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        asm_d      = asm_q;
        out_data_d = out_data_q;
        out_d      = 1'b0;
        drop_d     = 1'b0;
        word_inc   = 1'b0;
        drop_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_i) begin
                    asm_d[W_W-1 -: BYTE_W] = in_data_i;
                    lane_d  = LANE_W'(1);
                    state_d = FILL;
                end
            end
            FILL: begin
                if (!in_i) begin
                    drop_d   = 1'b1;
                    drop_inc = 1'b1;
                    lane_d   = '0;
                    state_d  = IDLE;
                end else if (lane_q == LAST_LANE) begin
                    // Last byte goes straight to the output; the slot itself is never written.
                    out_data_d = {asm_q[W_W-1:BYTE_W], in_data_i};
                    out_d      = 1'b1;
                    word_inc   = 1'b1;
                    lane_d     = '0;
                    state_d    = IDLE;
                end else begin
                    asm_d[W_W-1-BYTE_W*int'(lane_q) -: BYTE_W] = in_data_i;
                    lane_d = lane_q + LANE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                lane_d  = '0;
            end
        endcase
    end

    sat_counter #(.W(CNT_W), .SATURATE(1'b0)) u_word_cnt (
        .clk_i   (clk_4f_i),
        .reset_i (reset_i),
        .inc_i   (word_inc),
        .cnt_o   (word_cnt_o)
    );

    sat_counter #(.W(CNT_W), .SATURATE(1'b1)) u_drop_cnt (
        .clk_i   (clk_4f_i),
        .reset_i (reset_i),
        .inc_i   (drop_inc),
        .cnt_o   (drop_cnt_o)
    );

    assign out_data_o = out_data_q;
    assign out_o      = out_q;
    assign drop_o     = drop_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer: a vector table for the basic flow
// plus hand-written sequences for resets, back-to-back words and counter limits.
module tb_byte_word_packer;

    logic        clk_4f;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_v;
    logic [31:0] out_data;
    logic        out_v;
    logic        drop;
    logic [7:0]  word_cnt;
    logic [7:0]  drop_cnt;

    int n_total = 0;
    int n_pass  = 0;

    byte_word_packer dut (
        .clk_4f_i   (clk_4f),
        .reset_i    (reset),
        .in_data_i  (in_data),
        .in_i       (in_v),
        .out_data_o (out_data),
        .out_o      (out_v),
        .drop_o     (drop),
        .word_cnt_o (word_cnt),
        .drop_cnt_o (drop_cnt)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic        rst;
        logic        vin;
        logic [7:0]  din;
        logic        e_out;
        logic        e_drop;
        logic [31:0] e_data;
        logic [7:0]  e_wc;
        logic [7:0]  e_dc;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d);
        reset   = r;
        in_v    = v;
        in_data = d;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic eo, input logic ed,
                           input logic [31:0] edata, input logic [7:0] ewc, input logic [7:0] edc);
        chk({tag, ".out"},      {31'd0, out_v}, {31'd0, eo});
        chk({tag, ".drop"},     {31'd0, drop},  {31'd0, ed});
        chk({tag, ".out_data"}, out_data,       edata);
        chk({tag, ".word_cnt"}, {24'd0, word_cnt}, {24'd0, ewc});
        chk({tag, ".drop_cnt"}, {24'd0, drop_cnt}, {24'd0, edc});
    endtask

    function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic eo, logic ed,
                                logic [31:0] edata, logic [7:0] ewc, logic [7:0] edc);
        vec_t x;
        x.rst = r; x.vin = v; x.din = d; x.e_out = eo; x.e_drop = ed;
        x.e_data = edata; x.e_wc = ewc; x.e_dc = edc;
        return x;
    endfunction

    initial begin
        int outs;
        reset = 1'b1; in_v = 1'b0; in_data = 8'h00;

        // basic word, hold, drop, recovery word
        vt.push_back(mk(1, 0, 8'h00, 0, 0, 32'h0,        8'd0, 8'd0));
        vt.push_back(mk(0, 1, 8'hAA, 0, 0, 32'h0,        8'd0, 8'd0));
        vt.push_back(mk(0, 1, 8'hBB, 0, 0, 32'h0,        8'd0, 8'd0));
        vt.push_back(mk(0, 1, 8'hCC, 0, 0, 32'h0,        8'd0, 8'd0));
        vt.push_back(mk(0, 1, 8'hDD, 1, 0, 32'hAABBCCDD, 8'd1, 8'd0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 32'hAABBCCDD, 8'd1, 8'd0));
        vt.push_back(mk(0, 1, 8'h11, 0, 0, 32'hAABBCCDD, 8'd1, 8'd0));
        vt.push_back(mk(0, 1, 8'h22, 0, 0, 32'hAABBCCDD, 8'd1, 8'd0));
        vt.push_back(mk(0, 0, 8'h00, 0, 1, 32'hAABBCCDD, 8'd1, 8'd1));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 32'hAABBCCDD, 8'd1, 8'd1));
        vt.push_back(mk(0, 1, 8'h33, 0, 0, 32'hAABBCCDD, 8'd1, 8'd1));
        vt.push_back(mk(0, 1, 8'h44, 0, 0, 32'hAABBCCDD, 8'd1, 8'd1));
        vt.push_back(mk(0, 1, 8'h55, 0, 0, 32'hAABBCCDD, 8'd1, 8'd1));
        vt.push_back(mk(0, 1, 8'h66, 1, 0, 32'h33445566, 8'd2, 8'd1));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 32'h33445566, 8'd2, 8'd1));

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].rst, vt[i].vin, vt[i].din);
            chk_all($sformatf("vec%0d", i), vt[i].e_out, vt[i].e_drop, vt[i].e_data, vt[i].e_wc, vt[i].e_dc);
        end

        // 12 continuous bytes 01..0C after reset
        step(1, 0, 8'h00);
        outs = 0;
        for (int i = 1; i <= 12; i++) begin
            logic [31:0] ew;
            step(0, 1, 8'(i));
            if (i % 4 == 0) begin
                ew = {8'(i-3), 8'(i-2), 8'(i-1), 8'(i)};
                chk($sformatf("b2b%0d.out", i), {31'd0, out_v}, 32'd1);
                chk($sformatf("b2b%0d.data", i), out_data, ew);
            end
            if (out_v) outs++;
        end
        chk("b2b.outs", 32'(outs), 32'd3);
        chk("b2b.word_cnt", {24'd0, word_cnt}, 32'd3);
        step(0, 0, 8'h00);
        chk("b2b.idle_out", {31'd0, out_v}, 32'd0);

        // reset after 3 bytes of a word
        step(0, 1, 8'hE1); step(0, 1, 8'hE2); step(0, 1, 8'hE3);
        step(1, 1, 8'hE4);
        chk_all("rstmid", 0, 0, 32'h0, 8'd0, 8'd0);
        step(0, 1, 8'h12); step(0, 1, 8'h34); step(0, 1, 8'h56); step(0, 1, 8'h78);
        chk_all("rstmid.clean", 1, 0, 32'h12345678, 8'd1, 8'd0);
        step(0, 0, 8'h00);
        chk("rstmid.no_drop", {31'd0, drop}, 32'd0);

        // reset coincident with the 4th byte, then a clean word proves lane restarted
        step(0, 1, 8'hA1); step(0, 1, 8'hA2); step(0, 1, 8'hA3);
        step(1, 1, 8'hA4);
        chk_all("rst4th", 0, 0, 32'h0, 8'd0, 8'd0);
        step(0, 1, 8'h9A); step(0, 1, 8'hBC); step(0, 1, 8'hDE); step(0, 1, 8'hF0);
        chk_all("rst4th.clean", 1, 0, 32'h9ABCDEF0, 8'd1, 8'd0);

        // 300 drops saturate drop_cnt; out_data untouched
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 8'h5A);
            step(0, 0, 8'h00);
        end
        chk("sat.drop_cnt", {24'd0, drop_cnt}, 32'h0000_00FF);
        chk("sat.out_data", out_data, 32'h9ABCDEF0);
        chk("sat.word_cnt", {24'd0, word_cnt}, 32'd1);

        // 257 complete words wrap word_cnt to 1
        step(1, 0, 8'h00);
        for (int w = 0; w < 257; w++) begin
            for (int b = 0; b < 4; b++) step(0, 1, 8'(w + b));
        end
        chk("wrap.word_cnt", {24'd0, word_cnt}, 32'd1);
        chk("wrap.last_word", out_data, {8'(256), 8'(257), 8'(258), 8'(259)});
        chk("wrap.drop_cnt", {24'd0, drop_cnt}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Receive-side counterpart of the 32-to-8 transmit converter: packs a stream of valid-qualified bytes back into 32-bit words, MSB byte first.
- Sits directly downstream of the byte-lane link, in the clk_4f domain. Emits one registered 32-bit word plus a one-cycle valid strobe per four accepted bytes.
- Tracks dropped partial words so link-level errors are visible to the word-rate logic.

Parameters:
- BYTE_W, 8, width of one input lane in bits.
- BYTES, 4, bytes per output word; output width is BYTE_W*BYTES.
- CNT_W, 8, width of the word and drop status counters.

Ports:
- clk_4f  input  1  byte-rate clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- in_data  input  BYTE_W  incoming byte; MSB-first order within a word.
- in  input  1  byte valid; 0 means idle link and aborts any partial word.
- out_data  output  BYTE_W*BYTES  last completed word; held between words.
- out  output  1  one-cycle strobe: out_data updated this cycle.
- drop  output  1  one-cycle strobe: a partial word was discarded.
- word_cnt  output  CNT_W  completed words since reset; wraps 2^CNT_W-1 -> 0.
- drop_cnt  output  CNT_W  discarded partial words since reset; saturates at all-ones.

Behaviour:
- Reset: out_data=0, out=0, drop=0, word_cnt=0, drop_cnt=0, lane=0, assembly register=0, state=IDLE. Synchronous reset has priority over every other event in the same cycle.
- lane counter: 0..BYTES-1, width clog2(BYTES).
- IDLE (lane=0, no bytes held):
  - in=1: capture in_data into byte slot 0 (bits [31:24]), lane<=1, go to FILL.
  - in=0: stay in IDLE, no strobes.
- FILL (lane=1..BYTES-1):
  - in=1, lane<BYTES-1: capture into slot lane (slot k = bits [31-8k -: 8]), lane<=lane+1.
  - in=1, lane=BYTES-1: out_data<={assembled slots 0..2, in_data}, out<=1, word_cnt<=word_cnt+1, lane<=0, go to IDLE.
  - in=0: discard assembly, drop<=1, drop_cnt<=drop_cnt+1 (saturating), lane<=0, go to IDLE.
- Latency: out rises on the clock edge following the 4th accepted byte, i.e. the word is valid 1 cycle after its last byte is presented.
- Back-to-back operation: with in held at 1, the block emits one word every 4 cycles. out is never high on two consecutive cycles.
- out and drop are mutually exclusive and last exactly one cycle.
- out_data changes only on out. A drop does not disturb the previously completed word.
- Assembly slots are not cleared on completion or drop; they are overwritten by the next word.
- Reset mid-word: the partial word is discarded silently. No drop strobe, drop_cnt stays 0.
- All outputs are registered; no combinational path from in or in_data to any output.

Decomposition:
- Shared package: BYTE_W, BYTES, the word width constant, and the state encoding (IDLE=1'b0, FILL=1'b1) for reuse by the transmit converter and its bench.
- Natural sub-module: sat_counter (CNT_W-wide, increment-enable, optional saturate vs wrap). Instantiate it twice: word_cnt in wrap mode, drop_cnt in saturate mode.

Test Plan:
- Reset then bytes AA,BB,CC,DD with in=1 on 4 cycles -> next cycle out=1, out_data=AABBCCDD, word_cnt=1; following cycle out=0, out_data held.
- 12 continuous bytes 01..0C -> out pulses 3 times, 4 cycles apart, words 01020304, 05060708, 090A0B0C; word_cnt=3.
- Bytes 11,22 then in=0 -> drop=1 for one cycle, drop_cnt=1, out_data unchanged. A following 4-byte word 33445566 is emitted correctly.
- reset asserted after 3 bytes of a word -> all outputs 0 next cycle, no drop strobe. The next 4 bytes form a clean word.
- Drive 300 drop events -> drop_cnt saturates at FF. Drive 257 complete words -> word_cnt wraps to 01.
- reset and the 4th byte in the same cycle -> reset wins: out=0, word_cnt=0, lane=0.
